pipe_skid_buf: RTL

//  Two-entry ready/valid register slice (skid buffer) that feeds a downstream enable/set

---
 rtl/pipe_pkg.sv | 18 +
 rtl/skid_ctrl.sv | 108 ++++++++++
 rtl/pipe_skid_buf.sv | 83 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types for the pipe_skid_buf register slice.
//                skidstate_t encodes how many entries the slice holds.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

   // Occupancy-encoded controller state: 0, 1 or 2 entries held.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skidstate_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/skid_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : skid_ctrl
//  Description : State register and next-state logic of the two-entry skid
//                buffer. Every handshake output decodes from state_q alone,
//                so none of them depends combinationally on an input.
//  Ports       : clk, resetn        clock, async active-low reset
//                flush              synchronous discard of all entries
//                in_valid,out_ready upstream valid / downstream ready
//                in_ready,out_valid registered handshake outputs
//                occupancy          entries held (0..2)
//                load_main          enable for the main (head) register
//                load_skid          enable for the skid register
//                sel_skid           main register loads from skid, not input
//  Revision    : 1.0  initial release
// ============================================================================
module skid_ctrl
   import pipe_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       flush,
   input  logic       in_valid,
   input  logic       out_ready,
   output logic       in_ready,
   output logic       out_valid,
   output logic [1:0] occupancy,
   output logic       load_main,
   output logic       load_skid,
   output logic       sel_skid
);

   skidstate_t state_q;
   skidstate_t state_d;
   logic       push;
   logic       pop;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Decode from the state register only.
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      occupancy = 2'd0;
      case (state_q)
         BUSY: begin
            out_valid = 1'b1;
            occupancy = 2'd1;
         end
         FULL: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            occupancy = 2'd2;
         end
         default: ;
      endcase
   end

   assign push = in_valid  & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      state_d   = state_q;
      load_main = 1'b0;
      load_skid = 1'b0;
      sel_skid  = 1'b0;
      if (flush) begin
         // Flush wins over everything; a concurrent push is dropped.
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d   = BUSY;
                  load_main = 1'b1;
               end
            end
            BUSY: begin
               if (push && !pop) begin
                  state_d   = FULL;
                  load_skid = 1'b1;
               end else if (pop && !push) begin
                  // Main register keeps its last value while empty.
                  state_d = EMPTY;
               end else if (push && pop) begin
                  load_main = 1'b1;
               end
            end
            FULL: begin
               if (pop) begin
                  state_d   = BUSY;
                  load_main = 1'b1;
                  sel_skid  = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

endmodule : skid_ctrl
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_buf
//  Description : Two-entry ready/valid register slice. in_ready comes from a
//                flop, breaking the combinational ready path, while still
//                sustaining one transfer per cycle.
//  Ports       : clk, resetn         clock, async active-low reset
//                flush               discard entries, out_data <= FLUSHVAL
//                in_valid/in_ready/in_data     upstream interface
//                out_valid/out_ready/out_data  downstream interface
//                occupancy           entries held (0..2)
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int              WIDTH    = 8,
   parameter logic [WIDTH-1:0] FLUSHVAL = '0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   logic             load_main;
   logic             load_skid;
   logic             sel_skid;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_d;

   skid_ctrl u_ctrl (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .occupancy (occupancy),
      .load_main (load_main),
      .load_skid (load_skid),
      .sel_skid  (sel_skid)
   );

   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (flush) begin
         // Flush is the synchronous set of the downstream stage register.
         main_d = FLUSHVAL;
      end else begin
         if (load_main) begin
            main_d = sel_skid ? skid_q : in_data;
         end
         if (load_skid) begin
            skid_d = in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   assign out_data = main_q;

endmodule : pipe_skid_buf
`default_nettype wire
